galivan_rom_loader: RTL and testbench
=====================================

# galivan_rom_loader

Converts the 16-bit hps_io ROM download stream (ioctl index 0) into byte-wide, region-decoded write strobes for the Galivan core's ROM and PROM memories. It sits between hps_io and `core`, asserts `ioctl_wait` while it serialises each word, and produces the `rom_init` level that the core uses as its download/hold signal.

## Interface
Parameters (region sizes in bytes, packed back-to-back in download order from offset 0):
- R0_SIZE, 'h14000, main CPU program
- R1_SIZE, 'h08000, sound CPU program
- R2_SIZE, 'h04000, text tiles
- R3_SIZE, 'h20000, background tiles
- R4_SIZE, 'h10000, sprites
- R5_SIZE, 'h08000, background map
- R6_SIZE, 'h00500, colour PROMs

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  hps_io download active
- ioctl_index  in  8  hps_io file index; only 0 is accepted
- ioctl_addr  in  27  byte address of the current word (even)
- ioctl_dout  in  16  word; [7:0] is the byte at ioctl_addr, [15:8] the byte at +1
- ioctl_wr  in  1  one-cycle word strobe
- ioctl_wait  out  1  back-pressure to hps_io
- rom_init  out  1  high while a ROM download is in progress or draining
- rom_addr  out  18  region-relative byte address
- rom_data  out  8  byte to write
- rom_we  out  7  one-hot region write strobe, bit n = region n
- done  out  1  one-cycle pulse when a download completes
- overflow  out  1  sticky: a byte fell outside all regions or a word arrived while busy

## Operation
- Accept condition: `ioctl_wr & ioctl_download & (ioctl_index==0)` while in IDLE. Latch addr and dout, then go to LO.
- FSM states:
  - IDLE: the accept condition moves to LO.
  - LO: emit the byte at addr A from dout[7:0]; go to HI.
  - HI: emit the byte at A+1 from dout[15:8]; go to IDLE.
- Region decode uses cumulative bounds. Region n covers [Bn, Bn+Rn_SIZE), where B0=0 and Bn+1=Bn+Rn_SIZE.
  - rom_addr = byte address − Bn, truncated to 18 bits.
  - Exactly one rom_we bit is high for an in-range byte.
- A byte at or above B6+R6_SIZE ('h58500 by default) is dropped: rom_we stays 0 and overflow is set.
- An accept-condition word arriving in LO or HI is dropped and sets overflow. It is not queued.
- Non-zero ioctl_index downloads (DIP switches etc.) are ignored entirely. rom_init, ioctl_wait and rom_we are unaffected.
- rom_init:
  - Set the cycle after `ioctl_download & (ioctl_index==0)` is first seen.
  - Cleared once download has dropped and the FSM is IDLE.
- done pulses in the same cycle that rom_init falls. overflow is cleared only by reset.
- rom_addr and rom_data hold their last values when rom_we is 0.

## Timing
- Reset values: ioctl_wait=0, rom_init=0, rom_we=0, rom_addr=0, rom_data=0, done=0, overflow=0, FSM=IDLE.
- Word accepted at cycle N:
  - Low-byte rom_we at N+1.
  - High-byte rom_we at N+2.
  - ioctl_wait=1 during N+1 and N+2, and 0 from N+3.
  - The next word is acceptable at N+3.
- All outputs are registered. rom_we is a single-cycle pulse per byte.
- Download falling edge:
  - Seen at cycle M with the FSM in IDLE: rom_init=0 and done=1 at M+1.
  - Seen while in LO or HI: rom_init stays high until the HI byte is written; it falls, and done pulses, the cycle after HI.
- Reset mid-word: the pending byte is discarded and all outputs return to reset values the next cycle. No further rom_we is issued for that word.
- rom_init rising is not gated by ioctl_wr. It rises at D+1, where D is the first cycle download is high with index 0.

## Test plan
- Single word: addr 'h00000, dout 'hA55A. Expected: rom_we=7'b0000001 with addr 0/data 'h5A at N+1, then addr 1/data 'hA5 at N+2; ioctl_wait high N+1..N+2; overflow=0.
- Region boundary: word at addr 'h13FFE. Expected: both bytes to region 0 at 'h13FFE and 'h13FFF. Then word at 'h14000, dout 'h1234: region 1 (rom_we bit1), addr 0 data 'h34, addr 1 data 'h12.
- PROM end and overflow: word at 'h584FE goes to region 6, addr 'h4FE and 'h4FF. Then word at 'h58500: no rom_we and overflow=1, held until reset.
- Back-to-back violation: second ioctl_wr at N+1. Expected: second word dropped, overflow=1, only two rom_we pulses.
- Completion: download falls in the cycle of the HI state. Expected: rom_init falls and done pulses exactly once, the cycle after the HI write. Also: index 254 download with writes produces no rom_we and rom_init stays 0.
- Reset in LO: assert reset during LO. Expected: next cycle rom_we=0, ioctl_wait=0, rom_init=0, and no high-byte write follows.

Source files
------------

// File: rtl/galivan_rom_loader.sv
// rtl/galivan_rom_loader.sv - hps_io 16-bit ROM download to byte-wide region write strobes
module galivan_rom_loader #(
    parameter int unsigned R0_SIZE = 'h14000,
    parameter int unsigned R1_SIZE = 'h08000,
    parameter int unsigned R2_SIZE = 'h04000,
    parameter int unsigned R3_SIZE = 'h20000,
    parameter int unsigned R4_SIZE = 'h10000,
    parameter int unsigned R5_SIZE = 'h08000,
    parameter int unsigned R6_SIZE = 'h00500
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic        rom_init,
    output logic [17:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [6:0]  rom_we,
    output logic        done,
    output logic        overflow
);

    localparam int unsigned B1 = R0_SIZE;
    localparam int unsigned B2 = B1 + R1_SIZE;
    localparam int unsigned B3 = B2 + R2_SIZE;
    localparam int unsigned B4 = B3 + R3_SIZE;
    localparam int unsigned B5 = B4 + R4_SIZE;
    localparam int unsigned B6 = B5 + R5_SIZE;
    localparam int unsigned B7 = B6 + R6_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

    state_t      state_q, state_d;
    logic [26:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic [17:0] rom_addr_q, rom_addr_d;
    logic [7:0]  rom_data_q, rom_data_d;
    logic [6:0]  rom_we_q, rom_we_d;
    logic        rom_init_q, rom_init_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;

    logic        dl0, accept, emit;
    logic [26:0] byte_addr;
    logic [7:0]  byte_data;
    logic [24:0] dec;

    // Returns {one-hot region strobe, region-relative address}; strobe is 0 past the last region.
    function automatic logic [24:0] decode(input logic [26:0] a);
        logic [31:0] ax;
        logic [31:0] base;
        logic [31:0] rel;
        logic [6:0]  we;
        ax   = {5'd0, a};
        base = 32'd0;
        we   = 7'd0;
        if (ax < B1) begin
            we = 7'b0000001; base = 32'd0;
        end else if (ax < B2) begin
            we = 7'b0000010; base = B1;
        end else if (ax < B3) begin
            we = 7'b0000100; base = B2;
        end else if (ax < B4) begin
            we = 7'b0001000; base = B3;
        end else if (ax < B5) begin
            we = 7'b0010000; base = B4;
        end else if (ax < B6) begin
            we = 7'b0100000; base = B5;
        end else if (ax < B7) begin
            we = 7'b1000000; base = B6;
        end
        rel = ax - base;
        return {we, rel[17:0]};
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        rom_we_d   = 7'd0;
        rom_init_d = rom_init_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        emit       = 1'b0;
        byte_addr  = 27'd0;
        byte_data  = 8'd0;
        dl0        = ioctl_download && (ioctl_index == 8'd0);
        accept     = dl0 && ioctl_wr;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_LO;
                    addr_d    = ioctl_addr;
                    dout_d    = ioctl_dout;
                    emit      = 1'b1;
                    byte_addr = ioctl_addr;
                    byte_data = ioctl_dout[7:0];
                end
            end
            S_LO: begin
                state_d   = S_HI;
                emit      = 1'b1;
                byte_addr = addr_q + 27'd1;
                byte_data = dout_q[15:8];
                if (accept) overflow_d = 1'b1;
            end
            S_HI: begin
                state_d = S_IDLE;
                if (accept) overflow_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // The low byte is decoded straight from the bus so its strobe lands one cycle after accept.
        dec = decode(byte_addr);
        if (emit) begin
            if (dec[24:18] != 7'd0) begin
                rom_we_d   = dec[24:18];
                rom_addr_d = dec[17:0];
                rom_data_d = byte_data;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (dl0) begin
            rom_init_d = 1'b1;
        end else if (rom_init_q && (state_d == S_IDLE)) begin
            rom_init_d = 1'b0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            dout_q     <= '0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            rom_we_q   <= '0;
            rom_init_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            rom_we_q   <= rom_we_d;
            rom_init_q <= rom_init_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign ioctl_wait = (state_q != S_IDLE);
    assign rom_init   = rom_init_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign rom_we     = rom_we_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_galivan_rom_loader.sv
// tb/tb_galivan_rom_loader.sv - directed bench for galivan_rom_loader
module tb_galivan_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic        rom_init;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic [6:0]  rom_we;
    logic        done;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    galivan_rom_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wr       (ioctl_wr),
        .ioctl_wait     (ioctl_wait),
        .rom_init       (rom_init),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_we         (rom_we),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Byte-write snapshot: strobe, address, data, back-pressure.
    task automatic check_byte(input string tag, input logic [6:0] we, input logic [17:0] a,
                              input logic [7:0] d, input logic w);
        check({tag, ".we"},   rom_we,     we);
        check({tag, ".addr"}, rom_addr,   a);
        check({tag, ".data"}, rom_data,   d);
        check({tag, ".wait"}, ioctl_wait, w);
    endtask

    task automatic put_word(input logic [26:0] a, input logic [15:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = 27'd0;
        ioctl_dout     = 16'd0;
        ioctl_wr       = 1'b0;
        tick();
        tick();
        check_byte("reset", 7'd0, 18'd0, 8'd0, 1'b0);
        check("reset.rom_init", rom_init, 1'b0);
        check("reset.done",     done,     1'b0);
        check("reset.overflow", overflow, 1'b0);

        reset          = 1'b0;
        ioctl_download = 1'b1;
        tick();
        check("init_rise", rom_init, 1'b1);

        put_word(27'h00000, 16'hA55A);
        check_byte("single.lo", 7'b0000001, 18'h0, 8'h5A, 1'b1);
        tick();
        check_byte("single.hi", 7'b0000001, 18'h1, 8'hA5, 1'b1);
        tick();
        check_byte("single.idle", 7'd0, 18'h1, 8'hA5, 1'b0);
        check("single.overflow", overflow, 1'b0);

        put_word(27'h13FFE, 16'hBEEF);
        check_byte("r0end.lo", 7'b0000001, 18'h13FFE, 8'hEF, 1'b1);
        tick();
        check_byte("r0end.hi", 7'b0000001, 18'h13FFF, 8'hBE, 1'b1);
        tick();

        put_word(27'h14000, 16'h1234);
        check_byte("r1start.lo", 7'b0000010, 18'h0, 8'h34, 1'b1);
        tick();
        check_byte("r1start.hi", 7'b0000010, 18'h1, 8'h12, 1'b1);
        tick();

        put_word(27'h584FE, 16'hC3D4);
        check_byte("r6end.lo", 7'b1000000, 18'h4FE, 8'hD4, 1'b1);
        tick();
        check_byte("r6end.hi", 7'b1000000, 18'h4FF, 8'hC3, 1'b1);
        check("r6end.overflow", overflow, 1'b0);
        tick();

        put_word(27'h58500, 16'h5566);
        check_byte("past.lo", 7'd0, 18'h4FF, 8'hC3, 1'b1);
        check("past.overflow", overflow, 1'b1);
        tick();
        check_byte("past.hi", 7'd0, 18'h4FF, 8'hC3, 1'b1);
        tick();
        tick();
        check("past.sticky", overflow, 1'b1);

        put_word(27'h00010, 16'h2211);
        check_byte("fin.lo", 7'b0000001, 18'h10, 8'h11, 1'b1);
        tick();
        check_byte("fin.hi", 7'b0000001, 18'h11, 8'h22, 1'b1);
        check("fin.init_hi", rom_init, 1'b1);
        check("fin.no_done", done, 1'b0);
        ioctl_download = 1'b0;
        tick();
        check("fin.init_fall", rom_init, 1'b0);
        check("fin.done", done, 1'b1);
        tick();
        check("fin.done_once", done, 1'b0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst.overflow_clr", overflow, 1'b0);

        ioctl_download = 1'b1;
        ioctl_index    = 8'd254;
        tick();
        check("idx254.init", rom_init, 1'b0);
        put_word(27'h00000, 16'hFFFF);
        check("idx254.we_lo", rom_we, 7'd0);
        check("idx254.wait", ioctl_wait, 1'b0);
        tick();
        check("idx254.we_hi", rom_we, 7'd0);
        check("idx254.init2", rom_init, 1'b0);
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        tick();
        check("idx254.no_done", done, 1'b0);

        ioctl_download = 1'b1;
        tick();
        ioctl_addr = 27'h00100;
        ioctl_dout = 16'h7788;
        ioctl_wr   = 1'b1;
        tick();
        check_byte("b2b.lo", 7'b0000001, 18'h100, 8'h88, 1'b1);
        ioctl_addr = 27'h00200;
        ioctl_dout = 16'h9999;
        tick();
        ioctl_wr   = 1'b0;
        check_byte("b2b.hi", 7'b0000001, 18'h101, 8'h77, 1'b1);
        check("b2b.overflow", overflow, 1'b1);
        tick();
        check_byte("b2b.idle", 7'd0, 18'h101, 8'h77, 1'b0);
        tick();
        check("b2b.no_third", rom_we, 7'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        put_word(27'h00020, 16'hABCD);
        check_byte("rstlo.lo", 7'b0000001, 18'h20, 8'hCD, 1'b1);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        check_byte("rstlo.after", 7'd0, 18'h0, 8'h0, 1'b0);
        check("rstlo.init", rom_init, 1'b0);
        tick();
        check("rstlo.no_hi", rom_we, 7'd0);
        check("rstlo.done", done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
